// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the Lucid64 fetch stage: state encodings, widths,
// the PC increment and the default reset vector.
package fetch_stage_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 64;

    localparam logic [PC_WIDTH-1:0] PC_INC             = 64'd4;
    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_ADDR = 64'h0000_0000_0000_0000;

    typedef enum logic {
        FETCH_S_REQ  = 1'b0,
        FETCH_S_WAIT = 1'b1
    } fetch_state_e;

    // Word-align a PC by clearing its two low bits.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return pc & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {inst, pc} holding register. Keeps a returned instruction alive
// while decode is stalled; flush wins over load, load wins over drain.
module fetch_buffer
    import fetch_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic                  flush_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    output logic                  valid_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [PC_WIDTH-1:0]   pc_o
);

    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_inst;
    logic [PC_WIDTH-1:0]   r_pc;

    // Entry register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_inst  <= inst_i;
            r_pc    <= pc_i;
        end else if (drain_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign inst_o  = r_inst;
    assign pc_o    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Lucid64 instruction fetch stage. Owns the fetch PC, issues one outstanding
// word request at a time and presents {valid, pc, next_pc, inst} to decode.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target
// raises misaligned_o and halts fetch until an aligned redirect; without it the
// target is silently word-aligned.
//
// state | meaning
// REQ   | request asserted for fetch_pc (when buffer allows)
// WAIT  | request granted, awaiting rvalid; kill drops the response
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  imem_req_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  misaligned_o,
    output logic [PC_WIDTH-1:0]   misaligned_pc_o,
`endif
    output logic                  valid_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [PC_WIDTH-1:0]   next_pc_o,
    output logic [INST_WIDTH-1:0] inst_o
);

    fetch_state_e          r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [PC_WIDTH-1:0]   r_out_pc;
    logic                  r_kill, w_kill_nxt;

    logic                  w_buf_valid;
    logic [INST_WIDTH-1:0] w_buf_inst;
    logic [PC_WIDTH-1:0]   w_buf_pc;
    logic                  w_buf_load;
    logic                  w_buf_drain;

    logic                  w_req;
    logic                  w_grant;
    logic                  w_rsp_live;
    logic                  w_fetch_block;
    logic [PC_WIDTH-1:0]   w_redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  r_mis;
    logic [PC_WIDTH-1:0]   r_mis_pc;
    logic                  w_redirect_mis;

    assign w_redirect_mis  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_tgt  = redirect_pc_i;
    assign w_fetch_block   = r_mis;
    assign misaligned_o    = r_mis;
    assign misaligned_pc_o = r_mis_pc;

    // Trap flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mis    <= 1'b0;
            r_mis_pc <= '0;
        end else if (redirect_i) begin
            r_mis    <= w_redirect_mis;
            r_mis_pc <= w_redirect_mis ? redirect_pc_i : '0;
        end
    end
`else
    assign w_redirect_tgt = align_pc(redirect_pc_i);
    assign w_fetch_block  = 1'b0;
`endif

    // Handshake qualifiers; a new request may overlap the buffer draining.
    always_comb begin
        w_buf_drain = w_buf_valid && !stall_i;
        w_req       = rst_ni && (r_state == FETCH_S_REQ) && !w_fetch_block &&
                      (!w_buf_valid || w_buf_drain);
        w_grant     = w_req && imem_gnt_i;
        w_rsp_live  = rst_ni && (r_state == FETCH_S_WAIT) && imem_rvalid_i &&
                      !r_kill && !redirect_i;
        w_buf_load  = w_rsp_live && stall_i;
    end

    // Next-state logic; a redirect always overrides the next fetch PC.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_kill_nxt     = r_kill;
        case (r_state)
            FETCH_S_REQ: begin
                if (w_grant) begin
                    w_state_nxt    = FETCH_S_WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + PC_INC;
                    w_kill_nxt     = redirect_i;
                end
            end
            FETCH_S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = FETCH_S_REQ;
                    w_kill_nxt  = 1'b0;
                end else if (redirect_i) begin
                    w_kill_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FETCH_S_REQ;
            end
        endcase
        if (redirect_i) begin
            w_fetch_pc_nxt = w_redirect_tgt;
        end
    end

    // State, fetch PC, kill flag and the PC of the in-flight request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= FETCH_S_REQ;
            r_fetch_pc <= RESET_ADDR;
            r_kill     <= 1'b0;
            r_out_pc   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_kill     <= w_kill_nxt;
            if (w_grant) begin
                r_out_pc <= r_fetch_pc;
            end
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (w_buf_load),
        .drain_i (w_buf_drain),
        .flush_i (redirect_i),
        .inst_i  (imem_rdata_i),
        .pc_i    (r_out_pc),
        .valid_o (w_buf_valid),
        .inst_o  (w_buf_inst),
        .pc_o    (w_buf_pc)
    );

    // Presented instruction: buffer first, else the live response; zero when idle.
    always_comb begin
        valid_o = 1'b0;
        pc_o    = '0;
        inst_o  = '0;
        if (rst_ni && !redirect_i) begin
            if (w_buf_valid) begin
                valid_o = 1'b1;
                pc_o    = w_buf_pc;
                inst_o  = w_buf_inst;
            end else if (w_rsp_live) begin
                valid_o = 1'b1;
                pc_o    = r_out_pc;
                inst_o  = imem_rdata_i;
            end
        end
    end

    assign next_pc_o   = valid_o ? (pc_o + PC_INC) : '0;
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a transaction-level model of the
// expected instruction / request address streams, plus literal spot checks.
// A second instance starts at the top of the address space to cover PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [63:0] redirect_pc;
    logic        req, gnt, rvalid;
    logic [63:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [63:0] pc, next_pc;
    logic [31:0] inst;

    logic        req2, gnt2, rvalid2;
    logic [63:0] addr2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [63:0] pc2, next_pc2;
    logic [31:0] inst2;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis, mis2;
    logic [63:0] mis_pc, mis_pc2;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    logic gnt_en  = 1'b1;
    int   lat     = 1;

    always #5 clk = ~clk;

    assign gnt  = req & gnt_en;
    assign gnt2 = req2;

    fetch_stage u_dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned_o(mis), .misaligned_pc_o(mis_pc),
`endif
        .valid_o(valid), .pc_o(pc), .next_pc_o(next_pc), .inst_o(inst)
    );

    fetch_stage #(.RESET_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(64'd0), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_gnt_i(gnt2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned_o(mis2), .misaligned_pc_o(mis_pc2),
`endif
        .valid_o(valid2), .pc_o(pc2), .next_pc_o(next_pc2), .inst_o(inst2)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'h0000_0013;
        if (a == 64'd8) return 32'hDEAD_BEEF;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory models: sample handshake mid-cycle, answer just after the edge.
    logic        g_s, g2_s, pend;
    logic [63:0] a_s, a2_s, paddr;
    int          cnt;
    initial begin
        rvalid = 1'b0; rdata = '0; pend = 1'b0; cnt = 0; paddr = '0;
        rvalid2 = 1'b0; rdata2 = '0; g_s = 1'b0; g2_s = 1'b0; a_s = '0; a2_s = '0;
    end
    always @(negedge clk) begin
        g_s  = req & gnt;   a_s  = addr;
        g2_s = req2 & gnt2; a2_s = addr2;
    end
    always @(posedge clk) begin
        #1;
        rvalid = 1'b0;
        if (g_s) begin
            pend = 1'b1; paddr = a_s; cnt = lat - 1;
        end
        if (pend) begin
            if (cnt == 0) begin
                rvalid = 1'b1; rdata = mem_word(paddr); pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        rvalid2 = g2_s;
        rdata2  = mem_word(a2_s);
    end

    // Model: expected presented-PC stream and expected granted-address stream.
    logic [63:0] m_pc, m_req, h_pc, tgt;
    logic [31:0] h_inst;
    logic        m_hold, m_trap;
    initial begin
        m_pc = '0; m_req = '0; h_pc = '0; h_inst = '0; m_hold = 1'b0; m_trap = 1'b0; tgt = '0;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 64'(valid), 64'd0);
            check("rst_req", 64'(req), 64'd0);
            check("rst_pc", pc, 64'd0);
            check("rst_next_pc", next_pc, 64'd0);
            check("rst_inst", 64'(inst), 64'd0);
            m_pc = 64'd0; m_req = 64'd0; m_hold = 1'b0; m_trap = 1'b0;
        end else if (redirect) begin
            check("redirect_valid", 64'(valid), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = redirect_pc;
            m_trap = (redirect_pc[1:0] != 2'b00);
`else
            tgt = redirect_pc & ~64'd3;
`endif
            m_pc = tgt; m_req = tgt; m_hold = 1'b0;
        end else begin
            if (m_hold) begin
                check("hold_valid", 64'(valid), 64'd1);
                check("hold_pc", pc, h_pc);
                check("hold_inst", 64'(inst), 64'(h_inst));
            end
            if (m_trap) check("trap_no_req", 64'(req), 64'd0);
            if (valid) begin
                check("model_pc", pc, m_pc);
                check("model_inst", 64'(inst), 64'(mem_word(pc)));
                check("model_next_pc", next_pc, pc + 64'd4);
                if (stall) begin
                    check("stall_no_req", 64'(req), 64'd0);
                    m_hold = 1'b1; h_pc = pc; h_inst = inst;
                end else begin
                    m_hold = 1'b0; m_pc = m_pc + 64'd4;
                end
            end else begin
                m_hold = 1'b0;
            end
            if (req && gnt) begin
                check("model_req_addr", addr, m_req);
                m_req = m_req + 64'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, valid_o got 0 expected 1", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // First fetch from the reset vector, plus the wrapping instance.
        wait_valid("first");
        check("first_pc", pc, 64'd0);
        check("first_inst", 64'(inst), 64'h13);
        check("first_next_pc", next_pc, 64'd4);
        check("wrap_valid", 64'(valid2), 64'd1);
        check("wrap_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_next_pc", next_pc2, 64'd0);
        @(negedge clk);
        check("wrap_req", 64'(req2), 64'd1);
        check("wrap_req_addr", addr2, 64'd0);
        wait_valid("pc4");
        check("pc4", pc, 64'd4);

        // Stall across the pc-8 response for three cycles.
        step(); stall = 1'b1;
        wait_valid("pc8");
        check("pc8_pc", pc, 64'd8);
        check("pc8_inst", 64'(inst), 64'hDEAD_BEEF);
        check("pc8_no_req", 64'(req), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("pc8_held_pc", pc, 64'd8);
            check("pc8_held_no_req", 64'(req), 64'd0);
        end
        step(); stall = 1'b0;
        @(negedge clk);
        check("release_valid", 64'(valid), 64'd1);
        check("release_req", 64'(req), 64'd1);
        check("release_addr", addr, 64'd12);
        wait_valid("pc12");
        check("pc12", pc, 64'd12);

        // Ungranted request holds its address; a redirect may change it.
        step(); gnt_en = 1'b0;
        @(negedge clk);
        check("ungranted_addr", addr, 64'd16);
        step();
        @(negedge clk);
        check("ungranted_hold", addr, 64'd16);
        step(); redirect = 1'b1; redirect_pc = 64'h300;
        step(); redirect = 1'b0;
        @(negedge clk);
        check("ungranted_redir_req", 64'(req), 64'd1);
        check("ungranted_redir_addr", addr, 64'h300);
        step(); gnt_en = 1'b1;
        wait_valid("pc300");
        check("pc300", pc, 64'h300);

        // Redirect while waiting on a slow response: that response is dropped.
        lat = 3;
        step();
        step(); redirect = 1'b1; redirect_pc = 64'h100;
        step(); redirect = 1'b0;
        wait_valid("pc100");
        check("pc100_pc", pc, 64'h100);
        check("pc100_next_pc", next_pc, 64'h104);

        // Reset with a request outstanding; its rvalid lands right after reset.
        step();
        step(); rst_n = 1'b0;
        step();
        step(); rst_n = 1'b1; lat = 1;
        @(negedge clk);
        check("post_rst_rvalid_ignored", 64'(valid), 64'd0);
        check("post_rst_addr", addr, 64'd0);
        for (int i = 0; i < 4; i++) wait_valid("refetch");
        check("refetch_pc12", pc, 64'd12);

        // Redirect coincident with the grant for pc 16.
        step(); redirect = 1'b1; redirect_pc = 64'h200;
        @(negedge clk);
        check("coinc_gnt", 64'(req & gnt), 64'd1);
        check("coinc_addr", addr, 64'd16);
        step(); redirect = 1'b0;
        wait_valid("pc200");
        check("pc200_pc", pc, 64'h200);
        check("pc200_next_pc", next_pc, 64'h204);

        // Redirect beats stall and flushes the buffered instruction.
        step(); stall = 1'b1;
        wait_valid("pc204");
        check("pc204", pc, 64'h204);
        step(); redirect = 1'b1; redirect_pc = 64'h400;
        step(); redirect = 1'b0;
        @(negedge clk);
        check("flushed_valid", 64'(valid), 64'd0);
        check("flushed_addr", addr, 64'h400);
        step(); stall = 1'b0;
        wait_valid("pc400");
        check("pc400", pc, 64'h400);

`ifdef FETCH_MISALIGN_TRAP_EN
        step(); redirect = 1'b1; redirect_pc = 64'h102;
        step(); redirect = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("trap_flag", 64'(mis), 64'd1);
            check("trap_pc", mis_pc, 64'h102);
            check("trap_req", 64'(req), 64'd0);
        end
        step(); redirect = 1'b1; redirect_pc = 64'h200;
        step(); redirect = 1'b0;
        @(negedge clk);
        check("trap_cleared", 64'(mis), 64'd0);
        wait_valid("trap_resume");
        check("trap_resume_pc", pc, 64'h200);
`else
        step(); redirect = 1'b1; redirect_pc = 64'h502;
        step(); redirect = 1'b0;
        wait_valid("aligned");
        check("aligned_pc", pc, 64'h500);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
